// File: rtl/err_loc_pkg.sv
// -----------------------------------------------------------------------------
// err_loc_pkg
// Shared definitions for the error-location streamer:
//   - state_e      : emitter state (IDLE / EMIT)
//   - LOC_SENTINEL : all-ones location used for "no location" beats (default width)
//   - *_DEF        : default LOC_W / MAX_ERR / NUM_W for the streamer and slot buffer
// -----------------------------------------------------------------------------
package err_loc_pkg;

   localparam int LOC_W_DEF   = 10;
   localparam int MAX_ERR_DEF = 6;
   localparam int NUM_W_DEF   = 3;

   localparam logic [LOC_W_DEF-1:0] LOC_SENTINEL = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

endpackage

// File: rtl/err_loc_slot_buf.sv
// -----------------------------------------------------------------------------
// err_loc_slot_buf
// Holds one captured codeword result: all MAX_ERR locations, the error count
// and an occupancy flag. A load takes priority over a clear in the same cycle.
//
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the slot)
//   i_load         : capture i_loc / i_num and mark the slot occupied
//   i_clr          : mark the slot empty
//   i_loc, i_num   : codeword locations (slot k at [k*LOC_W +: LOC_W]) and count
//   o_loc, o_num   : stored locations and count
//   o_valid        : slot occupied
// -----------------------------------------------------------------------------
module err_loc_slot_buf
   import err_loc_pkg::*;
#(
   parameter int LOC_W   = LOC_W_DEF,
   parameter int MAX_ERR = MAX_ERR_DEF,
   parameter int NUM_W   = NUM_W_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_load,
   input  logic                     i_clr,
   input  logic [MAX_ERR*LOC_W-1:0] i_loc,
   input  logic [NUM_W-1:0]         i_num,
   output logic [MAX_ERR*LOC_W-1:0] o_loc,
   output logic [NUM_W-1:0]         o_num,
   output logic                     o_valid
);

   logic [MAX_ERR*LOC_W-1:0] loc_q, loc_d;
   logic [NUM_W-1:0]         num_q, num_d;
   logic                     valid_q, valid_d;

   always_comb begin
      loc_d   = loc_q;
      num_d   = num_q;
      valid_d = valid_q;
      if (i_load) begin
         loc_d   = i_loc;
         num_d   = i_num;
         valid_d = 1'b1;
      end else if (i_clr) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         loc_q   <= '0;
         num_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         loc_q   <= loc_d;
         num_q   <= num_d;
         valid_q <= valid_d;
      end
   end

   assign o_loc   = loc_q;
   assign o_num   = num_q;
   assign o_valid = valid_q;

endmodule

// File: rtl/err_loc_streamer.sv
// -----------------------------------------------------------------------------
// err_loc_streamer
// Captures the error locations of one selected decoder source and streams them
// out one location per beat over a valid/ready handshake. Counts outside
// 1..MAX_ERR produce a single all-ones sentinel beat (o_fail marks count >
// MAX_ERR). One codeword can wait in a pending slot while another is being
// emitted; a further codeword arriving then is dropped and flagged on the
// sticky o_overflow.
//
// Optional feature (macro ERR_LOC_STAT_EN): adds saturating statistics
//   o_cw_cnt  (16b) codewords fully emitted (last beat accepted)
//   o_err_cnt (20b) real (non-sentinel) location beats accepted
//
// Ports:
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_src_valid     : one-cycle offer of a codeword result
//   i_src_sel       : selected source; values >= N_SRC are ignored
//   i_src_loc       : source s slot k at [(s*MAX_ERR+k)*LOC_W +: LOC_W]
//   i_src_num       : source s count at [s*NUM_W +: NUM_W]
//   o_err_loc       : current location beat
//   o_valid, o_last, o_fail : beat valid, final beat, decode-failure beat
//   i_ready         : downstream accepts the beat when o_valid && i_ready
//   o_overflow      : sticky, a codeword was dropped
// -----------------------------------------------------------------------------
module err_loc_streamer
   import err_loc_pkg::*;
#(
   parameter int LOC_W   = LOC_W_DEF,
   parameter int MAX_ERR = MAX_ERR_DEF,
   parameter int N_SRC   = 4,
   parameter int NUM_W   = NUM_W_DEF,
   localparam int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_src_valid,
   input  logic [SEL_W-1:0]               i_src_sel,
   input  logic [N_SRC*MAX_ERR*LOC_W-1:0] i_src_loc,
   input  logic [N_SRC*NUM_W-1:0]         i_src_num,
   output logic [LOC_W-1:0]               o_err_loc,
   output logic                           o_valid,
   output logic                           o_last,
   output logic                           o_fail,
   input  logic                           i_ready,
   output logic                           o_overflow
`ifdef ERR_LOC_STAT_EN
   ,
   output logic [15:0]                    o_cw_cnt,
   output logic [19:0]                    o_err_cnt
`endif
);

   localparam int CW_W  = MAX_ERR * LOC_W;
   localparam int CNT_W = $clog2(MAX_ERR + 1);
   // Package sentinel is fixed at the default width; this one follows LOC_W.
   localparam logic [LOC_W-1:0] SENTINEL = {LOC_W{1'b1}};

   typedef struct packed {
      logic             fail;
      logic             last;
      logic [LOC_W-1:0] loc;
   } beat_t;

   // Beat idx of a codeword. Out-of-range counts collapse to one sentinel beat.
   function automatic beat_t beat_of(input logic [CW_W-1:0]  locs,
                                     input logic [NUM_W-1:0] num,
                                     input logic [CNT_W-1:0] idx);
      beat_t b;
      b.fail = 1'b0;
      b.last = 1'b1;
      b.loc  = SENTINEL;
      if (32'(num) > MAX_ERR) begin
         b.fail = 1'b1;
      end else if (num != '0) begin
         b.last = (32'(idx) == (32'(num) - 32'd1));
         b.loc  = locs[0 +: LOC_W];
         for (int k = 1; k < MAX_ERR; k++) begin
            if (32'(idx) == k) b.loc = locs[k*LOC_W +: LOC_W];
         end
      end
      return b;
   endfunction

   // ---------------------------------------------------------------- source mux
   logic [CW_W-1:0]  src_loc;
   logic [NUM_W-1:0] src_num;
   logic             cap;

   always_comb begin
      src_loc = '0;
      src_num = '0;
      for (int s = 0; s < N_SRC; s++) begin
         if (32'(i_src_sel) == s) begin
            src_loc = i_src_loc[s*CW_W +: CW_W];
            src_num = i_src_num[s*NUM_W +: NUM_W];
         end
      end
   end

   assign cap = i_src_valid && (32'(i_src_sel) < N_SRC);

   // ---------------------------------------------------------------- slots
   logic             act_load, act_clr, act_from_pend, act_valid;
   logic             pend_load, pend_clr, pend_valid;
   logic [CW_W-1:0]  act_loc, pend_loc, act_loc_in;
   logic [NUM_W-1:0] act_num, pend_num, act_num_in;

   assign act_loc_in = act_from_pend ? pend_loc : src_loc;
   assign act_num_in = act_from_pend ? pend_num : src_num;

   err_loc_slot_buf #(.LOC_W(LOC_W), .MAX_ERR(MAX_ERR), .NUM_W(NUM_W)) u_act (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (act_load),
      .i_clr   (act_clr),
      .i_loc   (act_loc_in),
      .i_num   (act_num_in),
      .o_loc   (act_loc),
      .o_num   (act_num),
      .o_valid (act_valid)
   );

   err_loc_slot_buf #(.LOC_W(LOC_W), .MAX_ERR(MAX_ERR), .NUM_W(NUM_W)) u_pend (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (pend_load),
      .i_clr   (pend_clr),
      .i_loc   (src_loc),
      .i_num   (src_num),
      .o_loc   (pend_loc),
      .o_num   (pend_num),
      .o_valid (pend_valid)
   );

   // ---------------------------------------------------------------- emitter
   state_e           state_q, state_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   beat_t            out_q, out_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             acc, last_acc;

   assign acc      = valid_q && i_ready;
   assign last_acc = acc && out_q.last;

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      out_d         = out_q;
      valid_d       = valid_q;
      ovf_d         = ovf_q;
      act_load      = 1'b0;
      act_clr       = 1'b0;
      act_from_pend = 1'b0;
      pend_load     = 1'b0;
      pend_clr      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cap) begin
               act_load = 1'b1;
               beat_d   = '0;
               out_d    = beat_of(src_loc, src_num, '0);
               valid_d  = 1'b1;
               state_d  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (last_acc) begin
               beat_d = '0;
               if (pend_valid) begin
                  // Pending moves up; a new offer this cycle still sees a
                  // full pending slot and is dropped.
                  act_load      = 1'b1;
                  act_from_pend = 1'b1;
                  pend_clr      = 1'b1;
                  out_d         = beat_of(pend_loc, pend_num, '0);
                  if (cap) ovf_d = 1'b1;
               end else if (cap) begin
                  // Offer lands exactly as the stream ends: go straight active.
                  act_load = 1'b1;
                  out_d    = beat_of(src_loc, src_num, '0);
               end else begin
                  act_clr = 1'b1;
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end else begin
               if (acc) begin
                  beat_d = beat_q + 1'b1;
                  out_d  = beat_of(act_loc, act_num, beat_q + 1'b1);
               end
               if (cap) begin
                  if (pend_valid) ovf_d = 1'b1;
                  else            pend_load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         out_q   <= '{fail: 1'b0, last: 1'b0, loc: SENTINEL};
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_err_loc  = out_q.loc;
   assign o_last     = out_q.last;
   assign o_fail     = out_q.fail;
   assign o_valid    = valid_q;
   assign o_overflow = ovf_q;

`ifdef ERR_LOC_STAT_EN
   // ---------------------------------------------------------------- statistics
   logic [15:0] cw_cnt_q, cw_cnt_d;
   logic [19:0] err_cnt_q, err_cnt_d;
   logic        act_is_loc;

   // The active slot always holds the codeword whose beat is presented.
   assign act_is_loc = act_valid && (act_num != '0) && (32'(act_num) <= MAX_ERR);

   always_comb begin
      cw_cnt_d  = cw_cnt_q;
      err_cnt_d = err_cnt_q;
      if (last_acc && (cw_cnt_q != '1))           cw_cnt_d  = cw_cnt_q + 1'b1;
      if (acc && act_is_loc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cw_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         cw_cnt_q  <= cw_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_cw_cnt  = cw_cnt_q;
   assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/err_loc_streamer.md
ERR_LOC_STREAMER -- requirements
Module: err_loc_streamer

Interface
REQ-001 Parameter LOC_W, default 10, error-location bit width.
REQ-002 Parameter MAX_ERR, default 6, max error locations per codeword (>=1).
REQ-003 Parameter N_SRC, default 4, number of candidate sources (>=1).
REQ-004 Parameter NUM_W, default 3, width of error-count fields (2^NUM_W > MAX_ERR).
REQ-005 i_clk  in  1  clock; i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_src_valid  in  1  one-cycle pulse offering a codeword result.
REQ-007 i_src_sel  in  $clog2(N_SRC) (min 1)  index of the selected source.
REQ-008 i_src_loc  in  N_SRC*MAX_ERR*LOC_W  flattened locations, source s, slot k at [(s*MAX_ERR+k)*LOC_W +: LOC_W].
REQ-009 i_src_num  in  N_SRC*NUM_W  flattened error counts per source.
REQ-010 o_err_loc  out  LOC_W  current location beat.
REQ-011 o_valid  out  1  beat valid; o_last  out  1  final beat of codeword; o_fail  out  1  decode-failure beat.
REQ-012 i_ready  in  1  downstream accepts beat when o_valid && i_ready.
REQ-013 o_overflow  out  1  sticky: a codeword was dropped.

Function
REQ-014 On i_src_valid, the block SHALL capture all MAX_ERR locations and count of source i_src_sel in one cycle; i_src_sel >= N_SRC SHALL be ignored (no capture, no overflow).
REQ-015 States: IDLE, EMIT; IDLE->EMIT on capture; EMIT->EMIT on beat accept with beats remaining or pending entry present; EMIT->IDLE on last-beat accept with no pending entry.
REQ-016 First beat SHALL be registered: o_valid high the cycle after capture (latency 1).
REQ-017 Count n in 1..MAX_ERR: n beats, slots 0..n-1 in slot order, o_last on beat n-1.
REQ-018 Count 0: one beat, o_err_loc = all-ones sentinel, o_last=1, o_fail=0.
REQ-019 Count > MAX_ERR: one beat, sentinel, o_last=1, o_fail=1.
REQ-020 o_err_loc/o_last/o_fail SHALL hold stable while o_valid && !i_ready.
REQ-021 One-entry pending buffer: a capture while in EMIT SHALL fill it; on last-beat accept, pending SHALL load and its first beat SHALL present the next cycle (no bubble beyond one cycle).
REQ-022 Capture while EMIT and pending full SHALL drop the new codeword and set o_overflow; existing beats unaffected.
REQ-023 Capture coinciding with last-beat accept and empty pending SHALL go straight to active (not pending).
REQ-024 Beat counter width $clog2(MAX_ERR+1); never exceeds MAX_ERR-1.

Reset
REQ-025 Reset: state IDLE, o_valid=0, o_last=0, o_fail=0, o_err_loc=all-ones, o_overflow=0, pending empty.
REQ-026 Reset mid-emission SHALL discard active and pending codewords with no further beats.

Configuration
REQ-027 Macro ERR_LOC_STAT_EN defined: adds outputs o_cw_cnt (16b) and o_err_cnt (20b), counting codewords emitted and non-sentinel beats accepted, saturating, cleared by reset.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Shared package err_loc_pkg SHALL hold the state enum, sentinel constant and default LOC_W/MAX_ERR/NUM_W.
REQ-030 Sub-module err_loc_slot_buf (one captured codeword: locations, count, valid) SHALL be instantiated twice (active, pending).

Verification
REQ-031 Source 2 count 3 locs {5,17,900}, i_ready=1 -> beats 5,17,900 on cycles t+1..t+3, o_last on 900.
REQ-032 Count 0 -> single beat 1023, o_last=1, o_fail=0; count 7 (MAX_ERR=6) -> single beat 1023, o_fail=1.
REQ-033 Count 6, i_ready low on beat 2 for 3 cycles -> beat 2 held stable, total 6 beats, no loss.
REQ-034 Three back-to-back pulses during 6-beat emission -> second queued and emitted immediately after, third dropped, o_overflow=1.
REQ-035 Reset asserted mid-beat 3 -> o_valid=0 next cycle, pending cleared, o_overflow=0.
REQ-036 With ERR_LOC_STAT_EN: two codewords, counts 2 and 0 -> o_cw_cnt=2, o_err_cnt=2.
